bus_fabric: RTL

- Parametrised successor to the single-cycle SoC data bus. Routes the core data port (req/gnt/rvalid) to NUM_SLV peripheral/memory slaves.
- Decodes a configurable region field against a per-slave region map.
- Adds what the fixed bus lacks:
  - per-slave wait states through a ready handshake;
  - error responses for unmapped addresses and slave errors;
  - a watchdog timeout for hung slaves.
- Sits between the core LSU port and the memories and peripherals (data_mem, instr_mem, UART, I2C, QSPI, timer, USB, GPIO).

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_addr_decoder.sv | 38 +++
 rtl/bus_fabric.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared state type and default address map for the data bus fabric.
package bus_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hBADC_0DE5;

  // Region owned by each slave, slave 0 in the low nibble: 0 data_mem, 2 instr_mem,
  // 3 uart, 4 i2c, 5 qspi, 6 timer, 7 usb, 8 gpio. Region 1 is reserved for flash.
  localparam logic [31:0] SLV_MAP_DEF = 32'h8765_4320;

  localparam int unsigned SLV_DATA_MEM  = 0;
  localparam int unsigned SLV_INSTR_MEM = 1;
  localparam int unsigned SLV_UART      = 2;
  localparam int unsigned SLV_I2C       = 3;
  localparam int unsigned SLV_QSPI      = 4;
  localparam int unsigned SLV_TIMER     = 5;
  localparam int unsigned SLV_USB       = 6;
  localparam int unsigned SLV_GPIO      = 7;

endpackage

// File: rtl/bus_addr_decoder.sv
// Region decoder: matches the region field against the slave map, lowest index wins.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLV  = 8,
  parameter int unsigned REGION_W = 4,
  parameter logic [NUM_SLV*REGION_W-1:0] SLV_MAP = SLV_MAP_DEF,
  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [REGION_W-1:0] region_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic [NUM_SLV-1:0]  hit_o,
  output logic                miss_o
);

  logic [NUM_SLV-1:0] match;

  genvar gi;
  for (gi = 0; gi < NUM_SLV; gi++) begin : g_match
    assign match[gi] = (region_i == SLV_MAP[gi*REGION_W +: REGION_W]);
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    sel_o = '0;
    hit_o = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_o    = SEL_W'(i);
        hit_o    = '0;
        hit_o[i] = 1'b1;
      end
    end
  end

  assign miss_o = ~|match;

endmodule

// File: rtl/bus_fabric.sv
// Data bus fabric: routes the core LSU port to NUM_SLV slaves with wait states,
// error responses for unmapped regions / slave errors, and a hung-slave timeout.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int unsigned NUM_SLV     = 8,
  parameter int unsigned REGION_LSB  = 13,
  parameter int unsigned REGION_W    = 4,
  parameter logic [NUM_SLV*REGION_W-1:0] SLV_MAP = SLV_MAP_DEF,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic [NUM_SLV-1:0]    slv_req_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_be_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [NUM_SLV-1:0]    slv_ready_i,
  input  logic [NUM_SLV*32-1:0] slv_rdata_i,
  input  logic [NUM_SLV-1:0]    slv_err_i
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 2);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [SEL_W-1:0]   dec_sel;
  logic [NUM_SLV-1:0] dec_hit;
  logic               dec_miss;
  logic [31:0]        rdata_arr [NUM_SLV];

  logic               gnt;
  logic [NUM_SLV-1:0] req_vec;
  logic               bc_we;
  logic [3:0]         bc_be;
  logic [31:0]        bc_addr;
  logic [31:0]        bc_wdata;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout;

  genvar gi;
  for (gi = 0; gi < NUM_SLV; gi++) begin : g_rdata
    assign rdata_arr[gi] = slv_rdata_i[gi*32 +: 32];
  end

  bus_addr_decoder #(
    .NUM_SLV  (NUM_SLV),
    .REGION_W (REGION_W),
    .SLV_MAP  (SLV_MAP)
  ) u_decoder (
    .region_i (data_addr_i[REGION_LSB +: REGION_W]),
    .sel_o    (dec_sel),
    .hit_o    (dec_hit),
    .miss_o   (dec_miss)
  );

  // cnt_q counts request cycles already spent; the timeout fires on the cycle that
  // would make the total reach TIMEOUT_CYC, so slv_req_o is up exactly that long.
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_inc >= CNT_W'(TIMEOUT_CYC));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt      = 1'b0;
    req_vec  = '0;
    bc_we    = we_q;
    bc_be    = be_q;
    bc_addr  = addr_q;
    bc_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        gnt      = 1'b1;
        bc_we    = data_we_i;
        bc_be    = data_be_i;
        bc_addr  = data_addr_i;
        bc_wdata = data_wdata_i;
        req_vec  = dec_hit & {NUM_SLV{data_req_i}};
        if (data_req_i) begin
          if (dec_miss) begin
            rvalid_d = 1'b1;
            rdata_d  = ERR_DATA;
            err_d    = 1'b1;
          end else if (slv_ready_i[dec_sel]) begin
            rvalid_d = 1'b1;
            rdata_d  = data_we_i ? '0 : rdata_arr[dec_sel];
            err_d    = slv_err_i[dec_sel];
          end else begin
            state_d = WAIT;
            sel_d   = dec_sel;
            we_d    = data_we_i;
            be_d    = data_be_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        req_vec[sel_q] = 1'b1;
        cnt_d          = cnt_inc;
        // A ready in the same cycle as the timeout takes priority.
        if (slv_ready_i[sel_q]) begin
          rvalid_d = 1'b1;
          rdata_d  = we_q ? '0 : rdata_arr[sel_q];
          err_d    = slv_err_i[sel_q];
          state_d  = IDLE;
        end else if (timeout) begin
          rvalid_d = 1'b1;
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Combinational paths are masked so every output reads 0 while reset is held.
  assign data_gnt_o    = rst_i & gnt;
  assign slv_req_o     = rst_i ? req_vec  : '0;
  assign slv_we_o      = rst_i & bc_we;
  assign slv_be_o      = rst_i ? bc_be    : '0;
  assign slv_addr_o    = rst_i ? bc_addr  : '0;
  assign slv_wdata_o   = rst_i ? bc_wdata : '0;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule
